// File: rtl/ofmap_streamer.sv
// ofmap_streamer: snapshots the accelerator's pooled output on a done rise and streams it over valid/ready
module ofmap_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int PIXEL_COUNT = 16,
    parameter int IDX_W       = $clog2(PIXEL_COUNT)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [0:PIXEL_COUNT-1][DATA_WIDTH-1:0] cnn_ofmap,
    input  logic                                   done,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [DATA_WIDTH-1:0]                  m_data,
    output logic                                   m_last,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic                                   overrun,
    input  logic                                   clr_overrun
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t                                 state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic                                   done_q, frame_done_q, overrun_q, overrun_d;
    logic [0:PIXEL_COUNT-1][DATA_WIDTH-1:0] frame_q;
    logic                                   done_rise, at_last, hs, hs_last, capture;
    assign done_rise  = done & ~done_q;
    assign at_last    = idx_q == IDX_W'(PIXEL_COUNT - 1);
    assign hs         = m_valid & m_ready;
    assign hs_last    = hs & at_last;
    assign capture    = done_rise & (state_q == IDLE | hs_last);
    assign m_valid    = state_q == STREAM;
    assign busy       = m_valid;
    assign m_last     = m_valid & at_last;
    assign m_data     = m_valid ? frame_q[idx_q] : '0;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    // next state: a capture (including one on the final handshake) always restarts at pixel 0
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        if (capture) begin
            state_d = STREAM;
            idx_d   = '0;
        end else if (hs_last) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (hs) begin
            idx_d = idx_q + 1'b1;
        end
        if (done_rise & m_valid & ~hs_last) overrun_d = 1'b1;
        else if (clr_overrun) overrun_d = 1'b0;
    end
    // control registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            done_q       <= done;
            frame_done_q <= hs_last;
            overrun_q    <= overrun_d;
        end
    end
    // frame buffer needs no reset; it is only read while streaming
    always_ff @(posedge clk) begin
        if (capture) frame_q <= cnn_ofmap;
    end
endmodule

// File: tb/tb_ofmap_streamer.sv
// tb_ofmap_streamer: randomized scenario bench for ofmap_streamer against a frame-queue reference model
module tb_ofmap_streamer;
    localparam int DW = 8;
    localparam int PC = 16;
    logic clk = 0, reset = 0, done = 0, m_ready = 0, clr_overrun = 0;
    logic [0:PC-1][DW-1:0] cnn_ofmap = '0;
    logic m_valid, m_last, busy, frame_done, overrun;
    logic [DW-1:0] m_data;
    int n_cmp = 0, n_err = 0;
    int ready_mode = 0, rk = 0;
    logic [DW-1:0] rx_data[$];
    logic rx_last[$];
    int rx_cyc[$];
    logic [DW-1:0] exp_data[$];
    logic exp_last[$];
    int ncyc = 0, fd_cnt = 0, fd_cyc = 0, busy_cnt = 0, stall_err = 0;
    logic pv = 0, pr = 0, pl = 0;
    logic [DW-1:0] pd = '0;

    ofmap_streamer #(.DATA_WIDTH(DW), .PIXEL_COUNT(PC)) dut (
        .clk(clk), .reset(reset), .cnn_ofmap(cnn_ofmap), .done(done),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rk++;
            m_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (rk % 4 == 0 || rk % 4 == 3) : 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        ncyc++;
        if (reset) begin
            if (m_valid && m_ready) begin
                rx_data.push_back(m_data);
                rx_last.push_back(m_last);
                rx_cyc.push_back(ncyc);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = ncyc;
            end
            if (busy) busy_cnt++;
            if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) stall_err++;
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        end else pv = 0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout want finish");
        $fatal(1);
    end

    task automatic model_frame(input logic [0:PC-1][DW-1:0] f);
        for (int i = 0; i < PC; i++) begin
            exp_data.push_back(f[i]);
            exp_last.push_back(i == PC - 1);
        end
    endtask

    function automatic int first_bad();
        for (int i = 0; i < exp_data.size(); i++)
            if (i >= rx_data.size() || rx_data[i] !== exp_data[i] || rx_last[i] !== exp_last[i]) return i;
        if (rx_data.size() != exp_data.size()) return exp_data.size();
        return -1;
    endfunction

    task automatic clear_logs();
        rx_data.delete(); rx_last.delete(); rx_cyc.delete();
        exp_data.delete(); exp_last.delete();
        fd_cnt = 0; busy_cnt = 0; stall_err = 0;
    endtask

    task automatic wait_idle(input int budget);
        int left = budget;
        do begin
            @(negedge clk);
            left--;
        end while (busy && left > 0);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, budget); end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 60 && rx_data.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (rx_data.size() < n) begin n_err++; $display("FAIL wait_rx: got %0d pixels, want %0d", rx_data.size(), n); end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 00", m_data); end
        n_cmp++; if ({m_last, busy, frame_done, overrun} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {m_last, busy, frame_done, overrun}); end
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic test_basic();
        logic [0:PC-1][DW-1:0] f;
        int b;
        ready_mode = 0;
        clear_logs();
        for (int i = 0; i < PC; i++) f[i] = DW'(i + 1);
        model_frame(f);
        cnn_ofmap = f;
        done = 1;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL basic_pre: m_valid=%b before capture, want 0", m_valid); end
        @(posedge clk);
        #1;
        done = 0;
        n_cmp++; if ({m_valid, busy} !== 2'b11) begin n_err++; $display("FAIL basic_latency: valid,busy=%b want 11", {m_valid, busy}); end
        wait_idle(100);
        b = first_bad();
        n_cmp++; if (b !== -1) begin n_err++; $display("FAIL basic_seq: first bad index %0d, want -1", b); end
        n_cmp++; if (rx_cyc.size() != PC || rx_cyc[PC-1] - rx_cyc[0] != PC - 1) begin n_err++; $display("FAIL basic_consec: %0d pixels not on consecutive cycles", rx_cyc.size()); end
        n_cmp++; if (busy_cnt != PC) begin n_err++; $display("FAIL basic_busy: busy cycles %0d want %0d", busy_cnt, PC); end
        n_cmp++; if (fd_cnt != 1) begin n_err++; $display("FAIL basic_fd_cnt: got %0d want 1", fd_cnt); end
        n_cmp++; if (rx_cyc.size() == PC && fd_cyc != rx_cyc[PC-1] + 1) begin n_err++; $display("FAIL basic_fd_time: got cycle %0d want %0d", fd_cyc, rx_cyc[PC-1] + 1); end
    endtask

    task automatic test_stall();
        logic [0:PC-1][DW-1:0] f;
        int b;
        ready_mode = 1;
        clear_logs();
        for (int i = 0; i < PC; i++) f[i] = DW'(i + 1);
        model_frame(f);
        cnn_ofmap = f;
        done = 1;
        @(posedge clk);
        #1;
        done = 0;
        wait_idle(200);
        b = first_bad();
        n_cmp++; if (b !== -1) begin n_err++; $display("FAIL stall_seq: first bad index %0d, want -1", b); end
        n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL stall_stable: %0d unstable stall cycles, want 0", stall_err); end
        n_cmp++; if (busy_cnt <= PC) begin n_err++; $display("FAIL stall_seen: busy cycles %0d, want > %0d", busy_cnt, PC); end
        n_cmp++; if (fd_cnt != 1) begin n_err++; $display("FAIL stall_fd: got %0d want 1", fd_cnt); end
    endtask

    task automatic test_isolation();
        logic [0:PC-1][DW-1:0] f;
        int b;
        ready_mode = 2;
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            for (int i = 0; i < PC; i++) f[i] = r == 0 ? DW'(i + 1) : DW'($urandom);
            model_frame(f);
            cnn_ofmap = f;
            done = 1;
            @(posedge clk);
            #1;
            done = 0;
            cnn_ofmap = '1;
            wait_idle(300);
            b = first_bad();
            n_cmp++; if (b !== -1) begin n_err++; $display("FAIL isolation_seq%0d: first bad index %0d, want -1", r, b); end
            n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL isolation_stable%0d: %0d unstable stall cycles, want 0", r, stall_err); end
        end
    endtask

    task automatic test_overrun();
        logic [0:PC-1][DW-1:0] f;
        int b;
        ready_mode = 0;
        clear_logs();
        for (int i = 0; i < PC; i++) f[i] = DW'($urandom);
        model_frame(f);
        cnn_ofmap = f;
        done = 1;
        @(posedge clk);
        #1;
        done = 0;
        wait_rx(5);
        done = 1;
        for (int i = 0; i < PC; i++) cnn_ofmap[i] = DW'($urandom);
        @(posedge clk);
        #1;
        done = 0;
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b want 1", overrun); end
        wait_idle(100);
        b = first_bad();
        n_cmp++; if (b !== -1) begin n_err++; $display("FAIL overrun_seq: first bad index %0d, want -1", b); end
        n_cmp++; if (fd_cnt != 1) begin n_err++; $display("FAIL overrun_fd: got %0d want 1", fd_cnt); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
        clr_overrun = 1;
        @(posedge clk);
        #1;
        clr_overrun = 0;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b want 0", overrun); end
        clear_logs();
        model_frame(f);
        cnn_ofmap = f;
        done = 1;
        @(posedge clk);
        #1;
        done = 0;
        wait_rx(3);
        done = 1;
        clr_overrun = 1;
        @(posedge clk);
        #1;
        done = 0;
        clr_overrun = 0;
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set_wins: got %b want 1", overrun); end
        wait_idle(100);
        clr_overrun = 1;
        @(posedge clk);
        #1;
        clr_overrun = 0;
    endtask

    task automatic test_back_to_back();
        logic [0:PC-1][DW-1:0] f1, f2;
        int b;
        ready_mode = 0;
        clear_logs();
        for (int i = 0; i < PC; i++) begin
            f1[i] = DW'(i + 1);
            f2[i] = DW'(8'hA0 + i);
        end
        model_frame(f1);
        model_frame(f2);
        cnn_ofmap = f1;
        done = 1;
        @(posedge clk);
        #1;
        done = 0;
        repeat (PC - 1) @(posedge clk);
        #1;
        n_cmp++; if (rx_data.size() != PC - 1) begin n_err++; $display("FAIL b2b_align: %0d pixels before final edge, want %0d", rx_data.size(), PC - 1); end
        cnn_ofmap = f2;
        done = 1;
        @(posedge clk);
        #1;
        done = 0;
        for (int i = 0; i < PC; i++) cnn_ofmap[i] = DW'($urandom);
        wait_idle(100);
        b = first_bad();
        n_cmp++; if (b !== -1) begin n_err++; $display("FAIL b2b_seq: first bad index %0d, want -1", b); end
        n_cmp++; if (rx_cyc.size() != 2 * PC || rx_cyc[2*PC-1] - rx_cyc[0] != 2 * PC - 1) begin n_err++; $display("FAIL b2b_gap: %0d pixels, valid gap present", rx_cyc.size()); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        n_cmp++; if (fd_cnt != 2) begin n_err++; $display("FAIL b2b_fd: got %0d want 2", fd_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [0:PC-1][DW-1:0] f;
        int b;
        ready_mode = 0;
        clear_logs();
        for (int i = 0; i < PC; i++) f[i] = DW'($urandom);
        cnn_ofmap = f;
        done = 1;
        @(posedge clk);
        #1;
        done = 0;
        wait_rx(7);
        #2;
        reset = 0;
        #1;
        n_cmp++; if ({m_valid, busy, m_last, frame_done, overrun, m_data} !== '0) begin n_err++; $display("FAIL rstmid_outputs: valid,busy,last,fd,ovr=%b data=%h want all 0", {m_valid, busy, m_last, frame_done, overrun}, m_data); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        n_cmp++; if (fd_cnt != 0) begin n_err++; $display("FAIL rstmid_fd: got %0d pulses want 0", fd_cnt); end
        clear_logs();
        for (int i = 0; i < PC; i++) f[i] = DW'($urandom);
        model_frame(f);
        cnn_ofmap = f;
        done = 1;
        repeat (50) @(posedge clk);
        #1;
        done = 0;
        wait_idle(100);
        b = first_bad();
        n_cmp++; if (b !== -1) begin n_err++; $display("FAIL rstmid_restart: first bad index %0d, want -1", b); end
        n_cmp++; if (fd_cnt != 1) begin n_err++; $display("FAIL held_done_frames: got %0d frames want 1", fd_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_isolation();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
